code_rom_load_ctrl: RTL
=======================

// Module: code_rom_load_ctrl
// PURPOSE
//  Sequences host programming of the debug harness code ROM: accepts a byte stream over valid/ready,
//  writes it to consecutive ROM addresses, and owns program_rom_mode and the CPU hold.
//  Sits between the host link (Python UI bridge) and the harness ROM write port. Reports done,
//  error and an 8-bit checksum so the host can confirm the image before issuing run/step commands.
// PARAMETERS
//  NUM_BYTES  44   code ROM size in bytes (NUM_INSTRS*4); bound for base+len check
//  ADDR_W     12   ROM byte-address width
// PORTS
//  clk              in   1       clock
//  reset            in   1       async reset, active-high
//  load_start       in   1       1-cycle pulse: begin load; load_base/load_len sampled this cycle
//  load_base        in   ADDR_W  first ROM byte address
//  load_len         in   ADDR_W  number of bytes to write
//  abort            in   1       cancel load in progress
//  byte_valid       in   1       host byte available
//  byte_data        in   8       host byte
//  byte_ready       out  1       block accepts byte this cycle
//  rom_we           out  1       ROM byte write strobe
//  rom_addr         out  ADDR_W  ROM write address
//  rom_wdata        out  8       ROM write data
//  program_rom_mode out  1       ROM address mux selects rom_addr (host) over CPU fetch
//  cpu_hold         out  1       hold CPU (drives harness halt/reset gating) while loading
//  load_busy        out  1       load in progress
//  load_done        out  1       1-cycle pulse: image fully written
//  load_error       out  1       sticky: bad range or abort; cleared by next accepted load_start
//  checksum         out  8       sum mod 256 of accepted bytes; stable from load_done until next start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (byte_ready, rom_we, rom_addr, rom_wdata, program_rom_mode,
//    cpu_hold, load_busy, load_done, load_error, checksum). Reset mid-load abandons the load at once.
//  States: IDLE, LOAD, FLUSH, DONE.
//  IDLE: on load_start, compute end = load_base + load_len in ADDR_W+1 bits (no wrap).
//    load_len==0 or end > NUM_BYTES -> load_error=1 next cycle, stay IDLE, no writes.
//    else -> LOAD; latch addr=load_base, remaining=load_len; checksum<=0; load_error<=0.
//  LOAD: byte_ready = (state==LOAD) & ~abort (only combinational path). Handshake = valid & ready.
//    On handshake in cycle k: rom_we=1, rom_addr=addr, rom_wdata=byte_data registered in cycle k+1;
//    addr+=1, remaining-=1, checksum+=byte_data (8-bit wrap). Gaps in byte_valid add no writes.
//    Handshake with remaining==1 -> FLUSH.
//    abort -> IDLE next cycle, load_error=1, byte in that cycle not accepted; a write registered
//    from the previous cycle still issues; no further writes.
//  FLUSH: 1 cycle; final rom_we visible; byte_ready=0 -> DONE.
//  DONE: 1 cycle; load_done=1 -> IDLE.
//  program_rom_mode = 1 in LOAD and FLUSH (covers every rom_we cycle); cpu_hold = load_busy =
//    1 in LOAD, FLUSH, DONE. rom_we never asserts while program_rom_mode=0.
//  load_start while not IDLE: ignored. abort in IDLE/FLUSH/DONE: ignored.
//  Latency: start -> byte_ready 1 cycle; last handshake -> load_done 2 cycles.
//  Minimum load (len=1, valid held): start T, handshake T+1, rom_we T+2, load_done T+3.
// STRUCTURE
//  Shared package dbg_pkg: state enum for this FSM, NUM_BYTES/NUM_INSTRS constants (also used by the
//  harness so ROM size has one definition), byte/addr width constants.
//  Single module, no sub-modules: one comb next-state/ready block plus one registered block for
//  state, counters, checksum and the write stage.
// TESTING
//  1 Reset assert mid-sim -> every output 0 same cycle; release -> IDLE, byte_ready=0.
//  2 base=0 len=4, bytes 13,00,50,00 with valid held -> rom_we 4 consecutive cycles addr 0..3,
//    load_done 2 cycles after 4th handshake, checksum=0x63, load_error=0, cpu_hold drops after DONE.
//  3 base=8 len=3, valid toggling 1,0,0,1,0,1 -> exactly 3 writes at addr 8,9,10, data in order.
//  4 base=40 len=8 (end 48>44), then len=0 -> load_error=1, no rom_we, load_busy never 1;
//    next valid start (base=0 len=1) clears load_error.
//  5 base=0 len=8, abort after 2 handshakes with valid still high -> 2 writes only, byte_ready=0
//    during abort, load_error=1, load_done never pulses, program_rom_mode/cpu_hold low next cycle.
//  6 load_start pulsed during LOAD -> ignored (addr, remaining unchanged); reset during FLUSH ->
//    outputs 0 immediately, no load_done.

Source files
------------

// File: rtl/dbg_pkg.sv
// ---------------------------------------------------------------------------
// dbg_pkg
//  Shared constants and types for the debug harness.
//  - NUM_INSTRS / NUM_BYTES: single definition of the code ROM size, used by
//    the harness ROM and by the ROM load controller.
//  - Byte and ROM address widths.
//  - State encoding of the code ROM load controller FSM.
// ---------------------------------------------------------------------------
package dbg_pkg;

   localparam int DBG_NUM_INSTRS = 11;
   localparam int DBG_NUM_BYTES  = DBG_NUM_INSTRS * 4;
   localparam int DBG_ADDR_W     = 12;
   localparam int DBG_BYTE_W     = 8;

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_LOAD  = 2'd1,
      LD_FLUSH = 2'd2,
      LD_DONE  = 2'd3
   } load_state_e;

endpackage

// File: rtl/code_rom_load_ctrl.sv
// ---------------------------------------------------------------------------
// code_rom_load_ctrl
//  Sequences host programming of the debug harness code ROM. A load is
//  opened with load_start (base/len), bytes then arrive over a valid/ready
//  stream and are written to consecutive ROM byte addresses one cycle after
//  each handshake. The block owns program_rom_mode (ROM address mux) and
//  cpu_hold while loading, and reports done, a sticky error and an 8-bit
//  checksum of the accepted bytes.
//
//  Ports
//   clk, reset        clock, async active-high reset
//   load_start        1-cycle pulse, samples load_base / load_len
//   load_base/len     first ROM byte address / byte count
//   abort             cancel a load in progress
//   byte_valid/data   host byte stream
//   byte_ready        block accepts a byte this cycle
//   rom_we/addr/wdata ROM byte write port (registered)
//   program_rom_mode  ROM address mux selects the host address
//   cpu_hold          hold the CPU while loading
//   load_busy         load in progress
//   load_done         1-cycle pulse after the final write
//   load_error        sticky: bad range or abort
//   checksum          sum mod 256 of accepted bytes
// ---------------------------------------------------------------------------
module code_rom_load_ctrl
   import dbg_pkg::*;
#(
   parameter int NUM_BYTES = DBG_NUM_BYTES,
   parameter int ADDR_W    = DBG_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W-1:0] load_len,
   input  logic              abort,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [7:0]        rom_wdata,
   output logic              program_rom_mode,
   output logic              cpu_hold,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_error,
   output logic [7:0]        checksum
);

   // Range bound in ADDR_W+1 bits so base+len cannot wrap past the check.
   localparam logic [ADDR_W:0] MAX_END = (ADDR_W+1)'(NUM_BYTES);

   load_state_e       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic [7:0]        csum_q, csum_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              err_q, err_d;

   logic              ready_c;
   logic              hs_c;
   logic [ADDR_W:0]   end_c;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      csum_d  = csum_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      err_d   = err_q;

      // abort masks ready directly so the byte offered alongside it is never taken
      ready_c = (state_q == LD_LOAD) && !abort;
      hs_c    = byte_valid && ready_c;
      end_c   = {1'b0, load_base} + {1'b0, load_len};

      unique case (state_q)
         LD_IDLE: begin
            if (load_start) begin
               if ((load_len == '0) || (end_c > MAX_END)) begin
                  err_d = 1'b1;
               end else begin
                  state_d = LD_LOAD;
                  addr_d  = load_base;
                  rem_d   = load_len;
                  csum_d  = 8'd0;
                  err_d   = 1'b0;
               end
            end
         end
         LD_LOAD: begin
            if (abort) begin
               state_d = LD_IDLE;
               err_d   = 1'b1;
            end else if (hs_c) begin
               we_d    = 1'b1;
               waddr_d = addr_q;
               wdata_d = byte_data;
               addr_d  = addr_q + 1'b1;
               rem_d   = rem_q - 1'b1;
               csum_d  = csum_q + byte_data;
               if (rem_q == ADDR_W'(1)) state_d = LD_FLUSH;
            end
         end
         // FLUSH exists so the last registered write still sees program_rom_mode
         LD_FLUSH: state_d = LD_DONE;
         LD_DONE:  state_d = LD_IDLE;
         default:  state_d = LD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LD_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         csum_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         csum_q  <= csum_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   assign byte_ready       = ready_c;
   assign rom_we           = we_q;
   assign rom_addr         = waddr_q;
   assign rom_wdata        = wdata_q;
   assign program_rom_mode = (state_q == LD_LOAD) || (state_q == LD_FLUSH);
   assign load_busy        = (state_q != LD_IDLE);
   assign cpu_hold         = (state_q != LD_IDLE);
   assign load_done        = (state_q == LD_DONE);
   assign load_error       = err_q;
   assign checksum         = csum_q;

endmodule
